// File: rtl/fu_nrm_pkg.sv
// Shared sizing helpers for the FU normaliser group-OR / coarse LZ pipeline.
package fu_nrm_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned ngrp(input int unsigned width, input int unsigned grp);
        return (width + grp - 1) / grp;
    endfunction

    // Lead-group index must also encode "none found" (= NGRP).
    function automatic int unsigned lead_w(input int unsigned width, input int unsigned grp);
        return clog2(ngrp(width, grp) + 1);
    endfunction

    function automatic int unsigned lz_w(input int unsigned width, input int unsigned grp);
        return clog2(ngrp(width, grp) * grp + 1);
    endfunction

    function automatic int unsigned lz_fine_w(input int unsigned grp);
        return clog2(grp);
    endfunction

endpackage

// File: rtl/fu_nrm_grp_lzd.sv
// One GRP-bit slice: OR flag, plus in-group leading-zero count when FU_NRM_LZ_FINE_EN is defined.
module fu_nrm_grp_lzd
    import fu_nrm_pkg::*;
#(
    parameter int unsigned GRP = 16
) (
    input  logic [0:GRP-1]                slice,
    output logic                          or_c
`ifdef FU_NRM_LZ_FINE_EN
    ,
    output logic [lz_fine_w(GRP)-1:0]     lz_c
`endif
);

    assign or_c = |slice;

`ifdef FU_NRM_LZ_FINE_EN
    localparam int unsigned FW = lz_fine_w(GRP);

    // Bit 0 is the MSB, so the lowest set index is the leading-zero count.
    always_comb begin
        lz_c = '0;
        for (int i = int'(GRP) - 1; i >= 0; i--) begin
            if (slice[i]) begin
                lz_c = FW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/fu_nrm_orgrp_pipe.sv
// Two-stage group-OR reducer and coarse leading-zero encoder with valid/hold/flush.
// Build option: FU_NRM_LZ_FINE_EN adds per-group fine LZ for an exact ex7_lz_cnt.
module fu_nrm_orgrp_pipe
    import fu_nrm_pkg::*;
#(
    parameter  int unsigned WIDTH = 163,
    parameter  int unsigned GRP   = 16,
    localparam int unsigned NGRP  = ngrp(WIDTH, GRP),
    localparam int unsigned LGW   = lead_w(WIDTH, GRP),
    localparam int unsigned LZW   = lz_w(WIDTH, GRP)
) (
    input  logic              nclk,
    input  logic              rst,
    input  logic              ex5_vld,
    input  logic [0:WIDTH-1]  ex5_res,
    input  logic              hold,
    input  logic              flush,
    output logic              ex5_rdy,
    output logic              ex7_vld,
    output logic [0:NGRP-1]   ex7_or_grp,
    output logic [0:LGW-1]    ex7_lead_grp,
    output logic              ex7_all_zero,
    output logic [0:LZW-1]    ex7_lz_cnt
);

    localparam int unsigned PW = NGRP * GRP;

    logic [0:PW-1]   res_pad;
    logic [0:NGRP-1] grp_or;

    logic            vld6_d, vld6_q;
    logic            vld7_d, vld7_q;
    logic [0:NGRP-1] or6_d, or6_q;
    logic [0:NGRP-1] or7_d, or7_q;
    logic [0:LGW-1]  lead7_d, lead7_q;
    logic            zero7_d, zero7_q;
    logic [0:LZW-1]  lz7_d, lz7_q;

    logic [0:LGW-1]  lead_c;
    logic            zero_c;
    logic [0:LZW-1]  lz_c;

`ifdef FU_NRM_LZ_FINE_EN
    localparam int unsigned FW = lz_fine_w(GRP);
    logic [NGRP-1:0][FW-1:0] grp_lz;
    logic [NGRP-1:0][FW-1:0] fine6_d, fine6_q;
`endif

    assign ex5_rdy = ~hold;

    // Zero-pad the LSB side so every group is a full slice.
    always_comb begin
        res_pad = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            res_pad[i] = ex5_res[i];
        end
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        fu_nrm_grp_lzd #(
            .GRP (GRP)
        ) u_lzd (
            .slice (res_pad[g*GRP +: GRP]),
            .or_c  (grp_or[g])
`ifdef FU_NRM_LZ_FINE_EN
            ,
            .lz_c  (grp_lz[g])
`endif
        );
    end

    // Lowest set group wins; an empty vector reports NGRP and full-width LZ.
    always_comb begin
        lead_c = LGW'(NGRP);
        zero_c = 1'b1;
        lz_c   = LZW'(NGRP * GRP);
        for (int g = int'(NGRP) - 1; g >= 0; g--) begin
            if (or6_q[g]) begin
                lead_c = LGW'(g);
                zero_c = 1'b0;
`ifdef FU_NRM_LZ_FINE_EN
                lz_c   = LZW'(g * int'(GRP)) + LZW'(fine6_q[g]);
`else
                lz_c   = LZW'(g * int'(GRP));
`endif
            end
        end
    end

    // Flush beats hold; data registers only load on an advancing valid op.
    always_comb begin
        vld6_d  = vld6_q;
        vld7_d  = vld7_q;
        or6_d   = or6_q;
        or7_d   = or7_q;
        lead7_d = lead7_q;
        zero7_d = zero7_q;
        lz7_d   = lz7_q;
`ifdef FU_NRM_LZ_FINE_EN
        fine6_d = fine6_q;
`endif
        if (flush) begin
            vld6_d = 1'b0;
            vld7_d = 1'b0;
        end else if (!hold) begin
            vld6_d = ex5_vld;
            vld7_d = vld6_q;
            if (ex5_vld) begin
                or6_d = grp_or;
`ifdef FU_NRM_LZ_FINE_EN
                fine6_d = grp_lz;
`endif
            end
            if (vld6_q) begin
                or7_d   = or6_q;
                lead7_d = lead_c;
                zero7_d = zero_c;
                lz7_d   = lz_c;
            end
        end
    end

    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            vld6_q  <= 1'b0;
            vld7_q  <= 1'b0;
            or6_q   <= '0;
            or7_q   <= '0;
            lead7_q <= '0;
            zero7_q <= 1'b0;
            lz7_q   <= '0;
`ifdef FU_NRM_LZ_FINE_EN
            fine6_q <= '0;
`endif
        end else begin
            vld6_q  <= vld6_d;
            vld7_q  <= vld7_d;
            or6_q   <= or6_d;
            or7_q   <= or7_d;
            lead7_q <= lead7_d;
            zero7_q <= zero7_d;
            lz7_q   <= lz7_d;
`ifdef FU_NRM_LZ_FINE_EN
            fine6_q <= fine6_d;
`endif
        end
    end

    assign ex7_vld      = vld7_q;
    assign ex7_or_grp   = or7_q;
    assign ex7_lead_grp = lead7_q;
    assign ex7_all_zero = zero7_q;
    assign ex7_lz_cnt   = lz7_q;

endmodule

// File: tb/tb_fu_nrm_orgrp_pipe.sv
// Bench for fu_nrm_orgrp_pipe: default (163/16) and small (40/8) instances against a bit-scan model.
module tb_fu_nrm_orgrp_pipe;

    logic nclk = 1'b0;
    logic rst;
    logic ex5_vld, hold, flush;
    logic [0:162] res_a;
    logic [0:39]  res_b;

    logic        a_rdy, a_vld, a_zero;
    logic [0:10] a_or;
    logic [0:3]  a_lead;
    logic [0:7]  a_lz;

    logic        b_rdy, b_vld, b_zero;
    logic [0:4]  b_or;
    logic [0:2]  b_lead;
    logic [0:5]  b_lz;

    int nchk = 0;
    int nerr = 0;

    always #5 nclk = ~nclk;

    fu_nrm_orgrp_pipe #(.WIDTH(163), .GRP(16)) dut_a (
        .nclk(nclk), .rst(rst), .ex5_vld(ex5_vld), .ex5_res(res_a), .hold(hold), .flush(flush),
        .ex5_rdy(a_rdy), .ex7_vld(a_vld), .ex7_or_grp(a_or), .ex7_lead_grp(a_lead),
        .ex7_all_zero(a_zero), .ex7_lz_cnt(a_lz)
    );

    fu_nrm_orgrp_pipe #(.WIDTH(40), .GRP(8)) dut_b (
        .nclk(nclk), .rst(rst), .ex5_vld(ex5_vld), .ex5_res(res_b), .hold(hold), .flush(flush),
        .ex5_rdy(b_rdy), .ex7_vld(b_vld), .ex7_or_grp(b_or), .ex7_lead_grp(b_lead),
        .ex7_all_zero(b_zero), .ex7_lz_cnt(b_lz)
    );

    typedef struct {
        longint orv;
        int     lead;
        bit     zero;
        int     lz;
    } exp_t;

    typedef struct {
        exp_t ea;
        exp_t eb;
        int   age;
    } item_t;

    item_t q[$];
    exp_t  last_a, last_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first set bit scanning from the MSB (index 0).
    function automatic exp_t model(input logic [0:255] r, input int w, input int g);
        exp_t e;
        int p;
        int ng;
        p = -1;
        ng = (w + g - 1) / g;
        for (int i = 0; i < w; i++) begin
            if (r[i] === 1'b1 && p < 0) p = i;
        end
        e.orv = 0;
        for (int k = 0; k < ng; k++) begin
            bit any;
            any = 1'b0;
            for (int i = k * g; i < k * g + g && i < w; i++) begin
                if (r[i] === 1'b1) any = 1'b1;
            end
            e.orv = (e.orv << 1) | longint'(any);
        end
        if (p < 0) begin
            e.lead = ng;
            e.zero = 1'b1;
            e.lz   = ng * g;
        end else begin
            e.lead = p / g;
            e.zero = 1'b0;
`ifdef FU_NRM_LZ_FINE_EN
            e.lz   = p;
`else
            e.lz   = (p / g) * g;
`endif
        end
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.orv = 0; e.lead = 0; e.zero = 1'b0; e.lz = 0;
        return e;
    endfunction

    function automatic logic [0:255] onebit(input int i);
        logic [0:255] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [0:255] gen(input int w);
        logic [0:255] r;
        int mode;
        int k;
        r = '0;
        mode = int'($urandom_range(0, 3));
        k = int'($urandom_range(0, w - 1));
        case (mode)
            0: r = '0;
            1: r[k] = 1'b1;
            2: for (int i = k; i < w; i++) r[i] = 1'($urandom);
            default: for (int i = 0; i < w; i++) r[i] = 1'($urandom);
        endcase
        return r;
    endfunction

    task automatic cmp_out();
        bit ev;
        ev = (q.size() > 0 && q[0].age == 2);
        if (ev) begin
            last_a = q[0].ea;
            last_b = q[0].eb;
        end
        chk("a_vld",  64'(a_vld),  64'(ev));
        chk("a_or",   64'(a_or),   64'(last_a.orv));
        chk("a_lead", 64'(a_lead), 64'(last_a.lead));
        chk("a_zero", 64'(a_zero), 64'(last_a.zero));
        chk("a_lz",   64'(a_lz),   64'(last_a.lz));
        chk("b_vld",  64'(b_vld),  64'(ev));
        chk("b_or",   64'(b_or),   64'(last_b.orv));
        chk("b_lead", 64'(b_lead), 64'(last_b.lead));
        chk("b_zero", 64'(b_zero), 64'(last_b.zero));
        chk("b_lz",   64'(b_lz),   64'(last_b.lz));
    endtask

    // One clock: drive, check ready, advance model at the edge, check outputs after it.
    task automatic step(input bit v, input bit h, input bit f, input logic [0:255] ra);
        logic [0:255] rb;
        item_t it;
        rb = gen(40);
        ex5_vld = v;
        hold    = h;
        flush   = f;
        res_a   = ra[0:162];
        res_b   = rb[0:39];
        #1;
        chk("a_rdy", 64'(a_rdy), 64'(!h));
        chk("b_rdy", 64'(b_rdy), 64'(!h));
        @(posedge nclk);
        if (f) begin
            q.delete();
        end else if (!h) begin
            foreach (q[i]) q[i].age++;
            while (q.size() > 0 && q[0].age > 2) q.delete(0);
            if (v) begin
                it.ea  = model(ra, 163, 16);
                it.eb  = model(rb, 40, 8);
                it.age = 1;
                q.push_back(it);
            end
        end
        #1;
        cmp_out();
    endtask

    initial begin
        logic [0:255] z;
        z = '0;
        rst = 1'b0; ex5_vld = 1'b0; hold = 1'b0; flush = 1'b0; res_a = '0; res_b = '0;
        last_a = zero_exp();
        last_b = zero_exp();
        #1 rst = 1'b1;
        #2;
        chk("rst_vld",  64'(a_vld),  64'(0));
        chk("rst_or",   64'(a_or),   64'(0));
        chk("rst_lead", 64'(a_lead), 64'(0));
        chk("rst_zero", 64'(a_zero), 64'(0));
        chk("rst_lz",   64'(a_lz),   64'(0));
        @(negedge nclk);
        @(negedge nclk);
        rst = 1'b0;
        @(posedge nclk);
        #1;

        // Bit 0 alone: group 0, no leading zeros.
        step(1, 0, 0, onebit(0));
        chk("t1_vld_early", 64'(a_vld), 64'(0));
        step(0, 0, 0, z);
        chk("t1_vld",  64'(a_vld),  64'(1));
        chk("t1_or",   64'(a_or),   64'(11'h400));
        chk("t1_lead", 64'(a_lead), 64'(0));
        chk("t1_lz",   64'(a_lz),   64'(0));
        chk("t1_zero", 64'(a_zero), 64'(0));

        // All-zero operand, then the last real bit (padded group).
        step(1, 0, 0, z);
        step(1, 0, 0, onebit(162));
        chk("t2_zero_lead", 64'(a_lead), 64'(11));
        chk("t2_zero_lz",   64'(a_lz),   64'(176));
        chk("t2_zero_flag", 64'(a_zero), 64'(1));
        chk("t2_zero_or",   64'(a_or),   64'(0));
        step(0, 0, 0, z);
        chk("t2_162_or",   64'(a_or),   64'(11'h001));
        chk("t2_162_lead", 64'(a_lead), 64'(10));

        step(1, 0, 0, onebit(37));
        step(0, 0, 0, z);
        chk("t3_lead", 64'(a_lead), 64'(2));
`ifdef FU_NRM_LZ_FINE_EN
        chk("t3_lz", 64'(a_lz), 64'(37));
`else
        chk("t3_lz", 64'(a_lz), 64'(32));
`endif
        step(0, 0, 0, z);

        // Back-to-back ops with a 3-cycle stall after the first enters.
        step(1, 0, 0, onebit(5));
        step(1, 1, 0, onebit(70));
        step(1, 1, 0, onebit(70));
        step(1, 1, 0, onebit(70));
        step(1, 0, 0, onebit(70));
        step(1, 0, 0, onebit(140));
        step(0, 0, 0, z);
        step(0, 0, 0, z);
        step(0, 0, 0, z);

        // Flush with both stages occupied, under hold, with a new op offered.
        step(1, 0, 0, onebit(20));
        step(1, 0, 0, onebit(100));
        step(1, 1, 1, onebit(50));
        chk("t5_vld_flushed", 64'(a_vld), 64'(0));
        step(1, 0, 0, onebit(90));
        step(0, 0, 0, z);
        chk("t5_vld_after", 64'(a_vld), 64'(1));
        chk("t5_lead_after", 64'(a_lead), 64'(5));

        // Async reset between edges while the pipe is busy.
        step(1, 0, 0, onebit(3));
        step(1, 0, 0, onebit(64));
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_vld",  64'(a_vld),  64'(0));
        chk("t6_rst_or",   64'(a_or),   64'(0));
        chk("t6_rst_lead", 64'(a_lead), 64'(0));
        chk("t6_rst_lz",   64'(a_lz),   64'(0));
        chk("t6_rst_bvld", 64'(b_vld),  64'(0));
        chk("t6_rst_blz",  64'(b_lz),   64'(0));
        q.delete();
        last_a = zero_exp();
        last_b = zero_exp();
        ex5_vld = 1'b0;
        @(posedge nclk);
        #3 rst = 1'b0;
        @(posedge nclk);
        #1;
        step(0, 0, 0, z);
        step(0, 0, 0, z);

        // Random sweep of data and handshake.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 19) == 0), gen(163));
        end
        for (int n = 0; n < 3; n++) step(0, 0, 0, z);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
